// File: rtl/serial_word_receiver_pkg.sv
// Shared encodings for the shift-register serial link (receive and transmit
// sides). FSM state and shift-direction constants are kept as plain 1-bit
// localparams so they match the legacy encodings on both ends.
package serial_link_pkg;

    localparam logic [0:0] ST_IDLE       = 1'b0;
    localparam logic [0:0] ST_SHIFT      = 1'b1;

    localparam logic [0:0] DIR_LSB_FIRST = 1'b0;
    localparam logic [0:0] DIR_MSB_FIRST = 1'b1;

endpackage

// File: rtl/serial_word_receiver_if.sv
// Bus bundle for serial_word_receiver.
//   Serial side (into receiver): bit_en, bit_in, frame_start, msb_first, abort
//   Word side  (out of receiver): word_data, word_valid; word_ready back in
//   Status: overrun (sticky, cleared by clr_overrun), busy, bit_count
// slave  = receiver view, master = line sampler / consumer view.
interface serial_word_receiver_if #(
    parameter int WIDTH = 8
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             bit_en;
    logic             bit_in;
    logic             frame_start;
    logic             msb_first;
    logic             abort;
    logic [WIDTH-1:0] word_data;
    logic             word_valid;
    logic             word_ready;
    logic             overrun;
    logic             clr_overrun;
    logic             busy;
    logic [CNT_W-1:0] bit_count;

    modport slave (
        input  bit_en, bit_in, frame_start, msb_first, abort, word_ready, clr_overrun,
        output word_data, word_valid, overrun, busy, bit_count
    );

    modport master (
        output bit_en, bit_in, frame_start, msb_first, abort, word_ready, clr_overrun,
        input  word_data, word_valid, overrun, busy, bit_count
    );

endinterface

// File: rtl/serial_word_receiver_sipo_shift_core.sv
// Serial-in/parallel-out shift register with a modulo-WIDTH bit counter.
//   clk, reset : clock, synchronous active-high reset
//   clr        : discard the partial word (counter and register to zero)
//   shift      : shift bit_in in this cycle (applied after clr if both set)
//   dir        : DIR_LSB_FIRST shifts right, DIR_MSB_FIRST shifts left
//   sr         : register contents after this cycle's shift (includes bit_in)
//   count      : bits collected in the current word, 0..WIDTH-1
//   done       : this cycle's shift completes a word
module sipo_shift_core
    import serial_link_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             shift,
    input  logic             dir,
    input  logic             bit_in,
    output logic [WIDTH-1:0] sr,
    output logic [CNT_W-1:0] count,
    output logic             done
);

    logic [WIDTH-1:0] sr_q, sr_d, base_sr;
    logic [CNT_W-1:0] cnt_q, cnt_d, base_cnt;

    always_comb begin
        base_sr  = clr ? '0 : sr_q;
        base_cnt = clr ? '0 : cnt_q;
        sr_d     = base_sr;
        cnt_d    = base_cnt;
        done     = 1'b0;
        if (shift) begin
            if (dir == DIR_MSB_FIRST) begin
                sr_d = {base_sr[WIDTH-2:0], bit_in};
            end else begin
                sr_d = {bit_in, base_sr[WIDTH-1:1]};
            end
            if (base_cnt == CNT_W'(WIDTH - 1)) begin
                cnt_d = '0;
                done  = 1'b1;
            end else begin
                cnt_d = base_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    // Next-state view lets the top capture the completed word on the same
    // edge that samples its final bit.
    assign sr    = sr_d;
    assign count = cnt_q;

endmodule

// File: rtl/serial_word_receiver.sv
// Receive end of the shift-register serial link: assembles strobed serial bits
// into WIDTH-bit words and presents them through a one-entry valid/ready
// holding register with a sticky overrun flag.
//   clk, reset : clock, synchronous active-high reset
//   bus        : serial input, word output handshake and status (slave view)
module serial_word_receiver
    import serial_link_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    serial_word_receiver_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [0:0]       state_q, state_d;
    logic [0:0]       dir_q, dir_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;

    logic             start, clr, shift, core_dir, done, load;
    logic [WIDTH-1:0] core_sr;
    logic [CNT_W-1:0] core_cnt;

    // abort outranks frame_start and bit_en; a start lets a coincident bit
    // count as bit 0 of the new frame, using the direction just presented.
    assign start    = bus.frame_start && !bus.abort;
    assign clr      = bus.abort || start;
    assign shift    = !bus.abort && bus.bit_en && (state_q == ST_SHIFT || start);
    assign core_dir = start ? bus.msb_first : dir_q;

    sipo_shift_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk    (clk),
        .reset  (reset),
        .clr    (clr),
        .shift  (shift),
        .dir    (core_dir),
        .bit_in (bus.bit_in),
        .sr     (core_sr),
        .count  (core_cnt),
        .done   (done)
    );

    always_comb begin
        state_d = state_q;
        if (bus.abort) begin
            state_d = ST_IDLE;
        end else if (start) begin
            state_d = ST_SHIFT;
        end

        dir_d = start ? bus.msb_first : dir_q;

        // Holding register is free if empty or being drained this very edge.
        load   = done && (!valid_q || bus.word_ready);
        data_d = load ? core_sr : data_q;

        if (load) begin
            valid_d = 1'b1;
        end else if (valid_q && bus.word_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        if (done && !load) begin
            ovr_d = 1'b1;
        end else if (bus.clr_overrun) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            dir_q   <= DIR_LSB_FIRST;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bus.word_data  = data_q;
    assign bus.word_valid = valid_q;
    assign bus.overrun    = ovr_q;
    assign bus.busy       = (state_q == ST_SHIFT);
    assign bus.bit_count  = core_cnt;

endmodule

// File: tb/tb_serial_word_receiver.sv
module tb_serial_word_receiver;

    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;

    serial_word_receiver_if #(.WIDTH(8)) bus ();

    serial_word_receiver #(
        .WIDTH (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: apply inputs at negedge, return 1 time unit after posedge.
    task automatic step(input logic rst, input logic be, input logic bi, input logic fs,
                        input logic msb, input logic ab, input logic rdy, input logic clr);
        @(negedge clk);
        reset           = rst;
        bus.bit_en      = be;
        bus.bit_in      = bi;
        bus.frame_start = fs;
        bus.msb_first   = msb;
        bus.abort       = ab;
        bus.word_ready  = rdy;
        bus.clr_overrun = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rdy, 1'b0);
    endtask

    // Sends the 8 bits of w (w[0] first if LSB-first, w[7] first if MSB-first).
    task automatic send_word(input logic [7:0] w, input logic msb, input logic fs,
                             input logic rdy, input logic rdy_last);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, msb ? w[7-i] : w[i], fs && (i == 0), msb, 1'b0,
                 (i == 7) ? rdy_last : rdy, 1'b0);
        end
    endtask

    task automatic test_reset;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (bus.word_valid !== 1'b0 || bus.overrun !== 1'b0 || bus.busy !== 1'b0 ||
            bus.bit_count !== 4'd0 || bus.word_data !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_state: valid=%b ovr=%b busy=%b cnt=%0d data=%h, want 0 0 0 0 00",
                     bus.word_valid, bus.overrun, bus.busy, bus.bit_count, bus.word_data);
        end
        // bit_en without frame_start is ignored in IDLE
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (bus.busy !== 1'b0 || bus.bit_count !== 4'd0) begin
            tests_failed++;
            $display("FAIL idle_ignores_bit: busy=%b cnt=%0d, want 0 0", bus.busy, bus.bit_count);
        end
    endtask

    task automatic test_lsb_first;
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        tests_run++;
        if (bus.busy !== 1'b1 || bus.bit_count !== 4'd1) begin
            tests_failed++;
            $display("FAIL lsb_first_bit: busy=%b cnt=%0d, want 1 1", bus.busy, bus.bit_count);
        end
        for (int i = 1; i < 7; i++) step(1'b0, 1'b1, (i == 2 || i == 5), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tests_run++;
        if (bus.word_valid !== 1'b0 || bus.bit_count !== 4'd7) begin
            tests_failed++;
            $display("FAIL lsb_seven_bits: valid=%b cnt=%0d, want 0 7", bus.word_valid, bus.bit_count);
        end
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tests_run++;
        if (bus.word_valid !== 1'b1 || bus.word_data !== 8'hA5 || bus.bit_count !== 4'd0 || bus.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL lsb_word: valid=%b data=%h cnt=%0d busy=%b, want 1 a5 0 1",
                     bus.word_valid, bus.word_data, bus.bit_count, bus.busy);
        end
        idle(1'b1);
        tests_run++;
        if (bus.word_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL lsb_consumed: valid=%b, want 0", bus.word_valid);
        end
    endtask

    task automatic test_msb_first;
        send_word(8'hA5, 1'b1, 1'b1, 1'b1, 1'b1);
        tests_run++;
        if (bus.word_valid !== 1'b1 || bus.word_data !== 8'hA5) begin
            tests_failed++;
            $display("FAIL msb_a5: valid=%b data=%h, want 1 a5", bus.word_valid, bus.word_data);
        end
        idle(1'b1);
        send_word(8'h3C, 1'b1, 1'b1, 1'b1, 1'b1);
        tests_run++;
        if (bus.word_valid !== 1'b1 || bus.word_data !== 8'h3C) begin
            tests_failed++;
            $display("FAIL msb_3c: valid=%b data=%h, want 1 3c", bus.word_valid, bus.word_data);
        end
        idle(1'b1);
    endtask

    task automatic test_backpressure;
        send_word(8'h11, 1'b0, 1'b1, 1'b0, 1'b0);
        tests_run++;
        if (bus.word_valid !== 1'b1 || bus.word_data !== 8'h11 || bus.overrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_first: valid=%b data=%h ovr=%b, want 1 11 0",
                     bus.word_valid, bus.word_data, bus.overrun);
        end
        send_word(8'h22, 1'b0, 1'b1, 1'b0, 1'b0);
        tests_run++;
        if (bus.word_valid !== 1'b1 || bus.word_data !== 8'h11 || bus.overrun !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_overrun: valid=%b data=%h ovr=%b, want 1 11 1",
                     bus.word_valid, bus.word_data, bus.overrun);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        tests_run++;
        if (bus.word_valid !== 1'b0 || bus.overrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_clear: valid=%b ovr=%b, want 0 0", bus.word_valid, bus.overrun);
        end
    endtask

    task automatic test_simultaneous;
        send_word(8'h5A, 1'b0, 1'b1, 1'b0, 1'b0);
        send_word(8'h96, 1'b0, 1'b1, 1'b0, 1'b1);
        tests_run++;
        if (bus.word_valid !== 1'b1 || bus.word_data !== 8'h96 || bus.overrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL simul_load: valid=%b data=%h ovr=%b, want 1 96 0",
                     bus.word_valid, bus.word_data, bus.overrun);
        end
        idle(1'b1);
        tests_run++;
        if (bus.word_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL simul_drain: valid=%b, want 0", bus.word_valid);
        end
    endtask

    task automatic test_back_to_back;
        send_word(8'h0F, 1'b0, 1'b1, 1'b1, 1'b1);
        tests_run++;
        if (bus.word_valid !== 1'b1 || bus.word_data !== 8'h0F) begin
            tests_failed++;
            $display("FAIL b2b_first: valid=%b data=%h, want 1 0f", bus.word_valid, bus.word_data);
        end
        send_word(8'hF0, 1'b0, 1'b0, 1'b1, 1'b1);
        tests_run++;
        if (bus.word_valid !== 1'b1 || bus.word_data !== 8'hF0 || bus.overrun !== 1'b0 || bus.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_second: valid=%b data=%h ovr=%b busy=%b, want 1 f0 0 1",
                     bus.word_valid, bus.word_data, bus.overrun, bus.busy);
        end
        idle(1'b1);
    endtask

    task automatic test_abort;
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, (i == 0), 1'b0, 1'b0, 1'b1, 1'b0);
        tests_run++;
        if (bus.bit_count !== 4'd5 || bus.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL abort_partial: cnt=%0d busy=%b, want 5 1", bus.bit_count, bus.busy);
        end
        // abort wins over coincident frame_start and bit_en
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        tests_run++;
        if (bus.bit_count !== 4'd0 || bus.busy !== 1'b0 || bus.word_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_state: cnt=%0d busy=%b valid=%b, want 0 0 0",
                     bus.bit_count, bus.busy, bus.word_valid);
        end
        send_word(8'hC3, 1'b0, 1'b1, 1'b1, 1'b1);
        tests_run++;
        if (bus.word_valid !== 1'b1 || bus.word_data !== 8'hC3) begin
            tests_failed++;
            $display("FAIL abort_next_word: valid=%b data=%h, want 1 c3", bus.word_valid, bus.word_data);
        end
        idle(1'b1);
    endtask

    task automatic test_reset_mid;
        send_word(8'h77, 1'b0, 1'b1, 1'b0, 1'b0);
        send_word(8'h88, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, (i == 0), 1'b0, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (bus.bit_count !== 4'd4 || bus.word_valid !== 1'b1 || bus.overrun !== 1'b1) begin
            tests_failed++;
            $display("FAIL pre_reset: cnt=%0d valid=%b ovr=%b, want 4 1 1",
                     bus.bit_count, bus.word_valid, bus.overrun);
        end
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (bus.word_valid !== 1'b0 || bus.bit_count !== 4'd0 || bus.overrun !== 1'b0 ||
            bus.busy !== 1'b0 || bus.word_data !== 8'h00) begin
            tests_failed++;
            $display("FAIL mid_reset: valid=%b cnt=%0d ovr=%b busy=%b data=%h, want 0 0 0 0 00",
                     bus.word_valid, bus.bit_count, bus.overrun, bus.busy, bus.word_data);
        end
    endtask

    initial begin
        tests_run       = 0;
        tests_failed    = 0;
        reset           = 1'b1;
        bus.bit_en      = 1'b0;
        bus.bit_in      = 1'b0;
        bus.frame_start = 1'b0;
        bus.msb_first   = 1'b0;
        bus.abort       = 1'b0;
        bus.word_ready  = 1'b0;
        bus.clr_overrun = 1'b0;

        test_reset();
        test_lsb_first();
        test_msb_first();
        test_backpressure();
        test_simultaneous();
        test_back_to_back();
        test_abort();
        test_reset_mid();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
